// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Bundles the instruction-issue handshake and the datapath control bus
//   driven by alu_sequencer.
//   master : instruction issuer (drives s/in, observes everything else)
//   slave  : the sequencer itself (samples s/in, drives the control bus)
//   Signals:
//     s, in            start request and 16-bit instruction
//     w, err           ready-for-instruction and illegal-instruction pulse
//     ALUop, shift     ALU operation and shifter control
//     sximm8           sign-extended 8-bit immediate
//     readnum/writenum register-file read/write addresses
//     write            register-file write enable
//     loada..loads     A, B, C and status register load strobes
//     asel, vsel       ALU A-input zero select, writeback source select
interface alu_sequencer_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic        err;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic [1:0]  vsel;

  modport master (
    output s, in,
    input  w, err, ALUop, shift, sximm8, readnum, writenum, write,
           loada, loadb, loadc, loads, asel, vsel
  );

  modport slave (
    input  s, in,
    output w, err, ALUop, shift, sximm8, readnum, writenum, write,
           loada, loadb, loadc, loads, asel, vsel
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle control FSM in front of the 16-bit ALU datapath. One
//   instruction is accepted per start handshake in WAIT, latched into IR,
//   decoded, then stepped through register reads, ALU execution, status
//   capture and register-file writeback. All outputs are Moore outputs
//   decoded from the current state and IR.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset (state WAIT, IR cleared)
//     bus    alu_sequencer_if.slave: s/in issue, control strobes out
//   Configuration macro:
//     ALU_SEQ_STATUS_ALL_EN  when defined, EXEC loads the status register
//                            for every ALU instruction, not only CMP.
module alu_sequencer (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  localparam logic [2:0] WAIT      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] LOAD_A    = 3'd2;
  localparam logic [2:0] LOAD_B    = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
  localparam logic [2:0] WB_REG    = 3'd5;
  localparam logic [2:0] WRITE_IMM = 3'd6;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic signed [7:0]  imm8;
  logic signed [15:0] imm16;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign imm8   = signed'(ir[7:0]);
  assign imm16  = 16'(imm8);

  // Instruction class decode
  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;
  logic is_legal;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

  // State and IR; IR only loads on an accepted start in WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if ((state == WAIT) && bus.s) begin
        ir <= bus.in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:      if (bus.s) state_nxt = DECODE;
      DECODE: begin
        if (is_mov_imm)                state_nxt = WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_nxt = LOAD_B;
        else if (is_alu)               state_nxt = LOAD_A;
        else                           state_nxt = WAIT;
      end
      LOAD_A:    state_nxt = LOAD_B;
      LOAD_B:    state_nxt = EXEC;
      EXEC:      state_nxt = is_cmp ? WAIT : WB_REG;
      WB_REG:    state_nxt = WAIT;
      WRITE_IMM: state_nxt = WAIT;
      default:   state_nxt = WAIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.w        = 1'b0;
    bus.err      = 1'b0;
    bus.ALUop    = op;
    bus.shift    = 2'b00;
    bus.sximm8   = imm16;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.vsel     = 2'b00;
    case (state)
      WAIT:   bus.w = 1'b1;
      DECODE: bus.err = ~is_legal;
      LOAD_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      LOAD_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        bus.shift   = sh;
      end
      EXEC: begin
        bus.shift = sh;
        // MOV reg passes B through the ALU as 0 + B
        bus.asel  = is_mov_reg;
        bus.loadc = ~is_cmp;
`ifdef ALU_SEQ_STATUS_ALL_EN
        bus.loads = 1'b1;
`else
        bus.loads = is_cmp;
`endif
      end
      WB_REG: begin
        bus.vsel     = 2'b00;
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      WRITE_IMM: begin
        bus.vsel     = 2'b01;
        bus.writenum = rn;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. A per-instruction schedule model
//   lists what the control bus must show in each cycle after a start is
//   accepted (index 0 is the decode cycle), followed by the idle cycle.
module tb_alu_sequencer;

  typedef struct packed {
    logic        w;
    logic        err;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
  } outs_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] ir_model;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    o.w        = bus.w;
    o.err      = bus.err;
    o.aluop    = bus.ALUop;
    o.shift    = bus.shift;
    o.sximm8   = bus.sximm8;
    o.readnum  = bus.readnum;
    o.writenum = bus.writenum;
    o.write    = bus.write;
    o.loada    = bus.loada;
    o.loadb    = bus.loadb;
    o.loadc    = bus.loadc;
    o.loads    = bus.loads;
    o.asel     = bus.asel;
    o.vsel     = bus.vsel;
    return o;
  endfunction

  // Instruction kinds: 0 illegal, 1 MOV imm, 2 MOV reg, 3 ADD, 4 CMP, 5 AND, 6 MVN
  function automatic int kind_of(logic [15:0] ir);
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return 1;
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return 2;
    if (ir[15:13] == 3'b101) return 3 + int'(ir[12:11]);
    return 0;
  endfunction

  function automatic int trace_len(logic [15:0] ir);
    case (kind_of(ir))
      0:       return 1;
      1:       return 2;
      3, 5:    return 5;
      default: return 4;
    endcase
  endfunction

  // Outputs with nothing asserted, still reflecting the held instruction
  function automatic outs_t quiet_out(logic [15:0] ir);
    outs_t o;
    o = '0;
    o.aluop  = ir[12:11];
    o.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return o;
  endfunction

  function automatic outs_t idle_out(logic [15:0] ir);
    outs_t o;
    o = quiet_out(ir);
    o.w = 1'b1;
    return o;
  endfunction

  function automatic outs_t step_out(logic [15:0] ir, int k);
    outs_t o;
    int    kd;
    logic  uses_a;
    int    ex;
    o      = quiet_out(ir);
    kd     = kind_of(ir);
    uses_a = (kd == 3) || (kd == 4) || (kd == 5);
    ex     = uses_a ? 3 : 2;
    if (k == 0) begin
      o.err = (kd == 0);
    end else if (kd == 1) begin
      o.write = 1'b1; o.writenum = ir[10:8]; o.vsel = 2'b01;
    end else if (uses_a && k == 1) begin
      o.loada = 1'b1; o.readnum = ir[10:8];
    end else if (k == ex - 1) begin
      o.loadb = 1'b1; o.readnum = ir[2:0]; o.shift = ir[4:3];
    end else if (k == ex) begin
      o.shift = ir[4:3];
      o.asel  = (kd == 2);
      o.loadc = (kd != 4);
`ifdef ALU_SEQ_STATUS_ALL_EN
      o.loads = 1'b1;
`else
      o.loads = (kd == 4);
`endif
    end else if (k == ex + 1) begin
      o.write = 1'b1; o.writenum = ir[7:5]; o.vsel = 2'b00;
    end
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t got;
    got = sample();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called in a WAIT cycle (at negedge); returns at the negedge of the
  // following idle cycle. noise: 0 s low, 1 random s/in, 2 s held high.
  task automatic run_instr(input logic [15:0] instr, input int noise);
    int n;
    bus.s  = 1'b1;
    bus.in = instr;
    @(posedge clk); #1;
    ir_model = instr;
    n = trace_len(instr);
    for (int k = 0; k < n; k++) begin
      bus.in = 16'($urandom);
      case (noise)
        1:       bus.s = 1'($urandom);
        2:       bus.s = 1'b1;
        default: bus.s = 1'b0;
      endcase
      @(negedge clk);
      check($sformatf("instr %h step %0d", instr, k), step_out(ir_model, k));
      @(posedge clk); #1;
    end
    bus.s  = 1'b0;
    bus.in = 16'($urandom);
    @(negedge clk);
    check($sformatf("instr %h idle", instr), idle_out(ir_model));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] x;
    logic [1:0]  pick;
    x    = 16'($urandom);
    pick = 2'($urandom);
    case (pick)
      2'd0: begin
        x[15:13] = 3'b110;
        x[11]    = ($urandom_range(0, 4) == 0) ? x[11] : 1'b0;
      end
      2'd1, 2'd2: x[15:13] = 3'b101;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    ir_model = 16'h0000;
    reset    = 1'b1;
    bus.s    = 1'b0;
    bus.in   = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in reset", idle_out(16'h0000));
    reset = 1'b0;
    @(negedge clk);
    check("after reset", idle_out(16'h0000));

    run_instr(16'hD1F8, 0);
    run_instr(16'hA140, 0);
    run_instr(16'hA900, 0);
    run_instr(16'hB869, 0);
    run_instr(16'hE000, 0);
    run_instr(16'hC01A, 0);
    run_instr(16'hA140, 2);
    run_instr(16'hD87F, 2);
    run_instr(16'hB1E2, 1);

    // Abort an ADD during its register-read phase
    bus.s  = 1'b1;
    bus.in = 16'hA140;
    @(posedge clk); #1;
    bus.s = 1'b0;
    ir_model = 16'hA140;
    @(negedge clk);
    check("abort step 0", step_out(ir_model, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort step 1", step_out(ir_model, 1));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async reset", idle_out(16'h0000));
    @(negedge clk);
    check("held reset", idle_out(16'h0000));
    reset = 1'b0;
    ir_model = 16'h0000;
    @(negedge clk);
    check("after abort", idle_out(16'h0000));

    for (int i = 0; i < 40; i++) begin
      run_instr(rand_instr(), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
